// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - shared constants, widths and FSM states for the NAND flash target
package nand_pkg;
   localparam int PAGE_BYTES = 512;
   localparam int PAGES      = 512;
   localparam int COL_W      = $clog2(PAGE_BYTES);
   localparam int ROW_W      = $clog2(PAGES);
   localparam int CNT_W      = 16;
   localparam int RST_CYCLES = 4;

   localparam logic [7:0] CMD_READ0   = 8'h00;
   localparam logic [7:0] CMD_READ1   = 8'h01;
   localparam logic [7:0] CMD_PROG    = 8'h80;
   localparam logic [7:0] CMD_CONFIRM = 8'h10;
   localparam logic [7:0] CMD_STATUS  = 8'h70;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   localparam logic [7:0] STATUS_READY = 8'hE0;
   localparam logic [7:0] STATUS_BUSY  = 8'hA0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_RD_BUSY,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_PG_BUSY,
      ST_RESET
   } state_t;
endpackage

// File: rtl/nand_flash_target_if.sv
// rtl/nand_flash_target_if.sv - flash pin bundle plus external page RAM port
// master = host/RAM side, slave = flash target side.
interface nand_flash_target_if;
   import nand_pkg::*;
   logic                   f_cle;
   logic                   f_ale;
   logic                   f_wen;
   logic                   f_ren;
   logic [7:0]             f_io_in;
   logic [7:0]             f_io_out;
   logic                   f_io_oe;
   logic                   f_rb;
   logic [ROW_W+COL_W-1:0] mem_addr;
   logic                   mem_we;
   logic [7:0]             mem_wdata;
   logic [7:0]             mem_rdata;

   modport master (
      output f_cle, f_ale, f_wen, f_ren, f_io_in, mem_rdata,
      input  f_io_out, f_io_oe, f_rb, mem_addr, mem_we, mem_wdata
   );
   modport slave (
      input  f_cle, f_ale, f_wen, f_ren, f_io_in, mem_rdata,
      output f_io_out, f_io_oe, f_rb, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/nand_page_buf.sv
// rtl/nand_page_buf.sv - 512x8 single-port page buffer with 1-cycle registered read
// Unwritten bytes read back as 0xFF; a clear drops the valid mask instead of writing every byte.
module nand_page_buf
   import nand_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_we,
   input  logic [COL_W-1:0] i_addr,
   input  logic [7:0]       i_wdata,
   output logic [7:0]       o_rdata
);
   logic [7:0]            r_mem [PAGE_BYTES];
   logic [PAGE_BYTES-1:0] r_valid;
   logic [7:0]            r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= '0;
         r_rdata <= '0;
      end else begin
         if (i_clear)   r_valid         <= '0;
         else if (i_we) r_valid[i_addr] <= 1'b1;
         r_rdata <= r_valid[i_addr] ? r_mem[i_addr] : 8'hFF;
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/nand_flash_target.sv
// rtl/nand_flash_target.sv - NAND flash device-side responder backed by an external RAM
// Decodes CLE/ALE/WEn latch cycles, serves reads on REn and programs pages through nand_page_buf.
module nand_flash_target
   import nand_pkg::*;
#(
   parameter int T_R    = 25,
   parameter int T_PROG = 200
) (
   input logic                clk,
   input logic                rst,
   nand_flash_target_if.slave bus
);
   localparam int PG_CYCLES = (T_PROG > PAGE_BYTES + 1) ? T_PROG : PAGE_BYTES + 1;
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(T_R - 1);
   localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PG_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

   state_t           r_state, w_next;
   logic             r_cle_s1, r_cle_s2, r_ale_s1, r_ale_s2;
   logic             r_wen_s1, r_wen_s2, r_wen_s3, r_ren_s1, r_ren_s2, r_ren_s3;
   logic [7:0]       r_io_s1, r_io_s2;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_addr_cnt;
   logic             r_is_read, r_status, r_we, r_io_oe;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col, r_wcol;
   logic [7:0]       r_io_out;

   logic             w_busy, w_buf_we, w_buf_clear, w_rd_mode;
   logic [COL_W-1:0] w_buf_addr;
   logic [7:0]       w_buf_rdata;
   logic             w_wen_rise, w_ren_rise, w_cmd, w_addr, w_data, w_reset_cmd, w_start;

   assign w_wen_rise  = r_wen_s2 & ~r_wen_s3;
   assign w_ren_rise  = r_ren_s2 & ~r_ren_s3;
   assign w_cmd       = w_wen_rise & r_cle_s2;
   assign w_addr      = w_wen_rise & r_ale_s2 & ~r_cle_s2;
   assign w_data      = w_wen_rise & ~r_ale_s2 & ~r_cle_s2;
   assign w_reset_cmd = w_cmd && (r_io_s2 == CMD_RESET);
   assign w_start     = w_cmd && !w_busy &&
                        (r_io_s2 == CMD_READ0 || r_io_s2 == CMD_READ1 || r_io_s2 == CMD_PROG);
   assign w_rd_mode   = r_status | (r_state == ST_RD_DATA);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_reset_cmd) begin
         w_next = ST_RESET;
      end else if (w_cmd && !w_busy && r_io_s2 != CMD_STATUS) begin
         case (r_io_s2)
            CMD_READ0, CMD_READ1, CMD_PROG: w_next = ST_ADDR;
            CMD_CONFIRM: w_next = (r_state == ST_WR_DATA) ? ST_PG_BUSY : ST_IDLE;
            default:     w_next = ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_ADDR:    if (w_addr && r_addr_cnt == 2'd2) w_next = r_is_read ? ST_RD_BUSY : ST_WR_DATA;
            ST_RD_BUSY: if (r_cnt == RD_LAST)  w_next = ST_RD_DATA;
            ST_PG_BUSY: if (r_cnt == PG_LAST)  w_next = ST_IDLE;
            ST_RESET:   if (r_cnt == RST_LAST) w_next = ST_IDLE;
            default:    ;
         endcase
      end
   end

   always_comb begin
      w_busy = 1'b0;
      case (r_state)
         ST_RD_BUSY, ST_PG_BUSY, ST_RESET: w_busy = 1'b1;
         default: ;
      endcase
      w_buf_we    = (r_state == ST_WR_DATA) && w_data;
      w_buf_clear = w_start && (r_io_s2 == CMD_PROG);
      w_buf_addr  = (r_state == ST_PG_BUSY) ? r_cnt[COL_W-1:0] : r_col;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cle_s1 <= 1'b0;  r_cle_s2 <= 1'b0;
         r_ale_s1 <= 1'b0;  r_ale_s2 <= 1'b0;
         r_wen_s1 <= 1'b1;  r_wen_s2 <= 1'b1;  r_wen_s3 <= 1'b1;
         r_ren_s1 <= 1'b1;  r_ren_s2 <= 1'b1;  r_ren_s3 <= 1'b1;
         r_io_s1  <= '0;    r_io_s2  <= '0;
         r_cnt      <= '0;
         r_addr_cnt <= '0;
         r_is_read  <= 1'b0;
         r_status   <= 1'b0;
         r_row      <= '0;
         r_col      <= '0;
         r_wcol     <= '0;
         r_we       <= 1'b0;
         r_io_oe    <= 1'b0;
         r_io_out   <= '0;
      end else begin
         r_cle_s1 <= bus.f_cle;    r_cle_s2 <= r_cle_s1;
         r_ale_s1 <= bus.f_ale;    r_ale_s2 <= r_ale_s1;
         r_wen_s1 <= bus.f_wen;    r_wen_s2 <= r_wen_s1;  r_wen_s3 <= r_wen_s2;
         r_ren_s1 <= bus.f_ren;    r_ren_s2 <= r_ren_s1;  r_ren_s3 <= r_ren_s2;
         r_io_s1  <= bus.f_io_in;  r_io_s2  <= r_io_s1;

         r_cnt <= (w_next != r_state || w_reset_cmd) ? '0 : r_cnt + 1'b1;

         if (w_cmd) r_status <= (r_io_s2 == CMD_STATUS);

         if (w_start) begin
            r_is_read          <= (r_io_s2 != CMD_PROG);
            r_col[COL_W-1]     <= (r_io_s2 == CMD_READ1);
            r_addr_cnt         <= '0;
         end else if (r_state == ST_ADDR && w_addr) begin
            case (r_addr_cnt)
               2'd0:    r_col[COL_W-2:0] <= r_io_s2;
               2'd1:    r_row[ROW_W-2:0] <= r_io_s2;
               2'd2:    r_row[ROW_W-1]   <= r_io_s2[0];
               default: ;
            endcase
            r_addr_cnt <= r_addr_cnt + 2'd1;
         end else if (w_buf_we || (r_state == ST_RD_DATA && !r_status && w_ren_rise)) begin
            r_col <= r_col + 1'b1;
         end

         // Copy-out is one cycle behind the buffer read; an abort kills the pending write.
         r_we   <= (r_state == ST_PG_BUSY) && (w_next == ST_PG_BUSY) && (r_cnt < CNT_W'(PAGE_BYTES));
         r_wcol <= r_cnt[COL_W-1:0];

         r_io_oe <= w_rd_mode & ~r_ren_s2;
         if (r_status)                  r_io_out <= w_busy ? STATUS_BUSY : STATUS_READY;
         else if (r_state == ST_RD_DATA) r_io_out <= bus.mem_rdata;
      end
   end

   nand_page_buf u_page_buf (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_buf_clear),
      .i_we    (w_buf_we),
      .i_addr  (w_buf_addr),
      .i_wdata (r_io_s2),
      .o_rdata (w_buf_rdata)
   );

   assign bus.f_rb      = ~w_busy;
   assign bus.f_io_out  = r_io_out;
   assign bus.f_io_oe   = r_io_oe;
   assign bus.mem_we    = r_we;
   assign bus.mem_wdata = r_we ? w_buf_rdata : 8'h00;
   assign bus.mem_addr  = r_we ? {r_row, r_wcol} : {r_row, r_col};
endmodule

// File: tb/tb_nand_flash_target.sv
// tb/tb_nand_flash_target.sv - directed self-checking bench for nand_flash_target
module tb_nand_flash_target;
   import nand_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_writes = 0;
   bit   preloaded = 1'b0;
   logic [7:0] ram [0:262143];

   nand_flash_target_if bif ();

   nand_flash_target #(.T_R(25), .T_PROG(200)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!preloaded) begin
         for (int k = 0; k < 262144; k++) ram[k] <= k[7:0];
         preloaded <= 1'b1;
      end else begin
         if (bif.mem_we) begin
            ram[bif.mem_addr] <= bif.mem_wdata;
            n_writes <= n_writes + 1;
         end
         bif.mem_rdata <= ram[bif.mem_addr];
      end
   end

   task automatic send(input bit cle, input bit ale, input logic [7:0] v, input bit hold);
      @(negedge clk);
      bif.f_cle = cle; bif.f_ale = ale; bif.f_io_in = v; bif.f_wen = 1'b0;
      repeat (3) @(negedge clk);
      bif.f_wen = 1'b1;
      if (!hold) repeat (3) @(negedge clk);
   endtask

   task automatic read_byte(output logic [7:0] d, output logic oe);
      bif.f_ren = 1'b0;
      repeat (4) @(negedge clk);
      d  = bif.f_io_out;
      oe = bif.f_io_oe;
      bif.f_ren = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!bif.f_rb) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic test_reset();
      int w0;
      n_vec++; if (bif.f_rb !== 1'b1) begin n_bad++; $display("FAIL reset_rb got %b want 1", bif.f_rb); end
      n_vec++; if (bif.f_io_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", bif.f_io_oe); end
      n_vec++; if (bif.f_io_out !== 8'h00) begin n_bad++; $display("FAIL reset_out got %h want 00", bif.f_io_out); end
      n_vec++; if ({bif.mem_we, bif.mem_addr, bif.mem_wdata} !== 27'd0) begin
         n_bad++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h want 0", bif.mem_we, bif.mem_addr, bif.mem_wdata);
      end
      w0 = n_writes;
      for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 8'h5A, 1'b0);
      repeat (5) @(negedge clk);
      n_vec++; if (n_writes !== w0) begin n_bad++; $display("FAIL stray_data_writes got %0d want 0", n_writes - w0); end
   endtask

   task automatic test_read();
      int n; logic [7:0] d; logic oe;
      logic [7:0] exp [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      send(1'b1, 1'b0, CMD_READ0, 1'b0);
      send(1'b0, 1'b1, 8'h10, 1'b0);
      send(1'b0, 1'b1, 8'h03, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b1);
      measure_busy(n);
      n_vec++; if (n !== 25) begin n_bad++; $display("FAIL read_busy got %0d want 25", n); end
      for (int i = 0; i < 4; i++) begin
         read_byte(d, oe);
         n_vec++; if (d !== exp[i] || oe !== 1'b1) begin
            n_bad++; $display("FAIL read_byte%0d got %h oe=%b want %h oe=1", i, d, oe, exp[i]);
         end
      end
      n_vec++; if (bif.f_io_oe !== 1'b0) begin n_bad++; $display("FAIL read_oe_release got %b want 0", bif.f_io_oe); end
   endtask

   task automatic test_wrap();
      int n; logic [7:0] d; logic oe;
      logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      send(1'b1, 1'b0, CMD_READ1, 1'b0);
      send(1'b0, 1'b1, 8'hFE, 1'b0);
      send(1'b0, 1'b1, 8'h01, 1'b0);
      send(1'b0, 1'b1, 8'h01, 1'b1);
      measure_busy(n);
      n_vec++; if (n !== 25) begin n_bad++; $display("FAIL wrap_busy got %0d want 25", n); end
      for (int i = 0; i < 4; i++) begin
         read_byte(d, oe);
         n_vec++; if (d !== exp[i]) begin n_bad++; $display("FAIL wrap_byte%0d got %h want %h", i, d, exp[i]); end
      end
   endtask

   task automatic test_program();
      int n; int nff;
      send(1'b1, 1'b0, CMD_PROG, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b1, 8'h05, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b0, 8'hAA, 1'b0);
      send(1'b0, 1'b0, 8'h55, 1'b0);
      send(1'b1, 1'b0, CMD_CONFIRM, 1'b1);
      measure_busy(n);
      n_vec++; if (n !== 513) begin n_bad++; $display("FAIL prog_busy got %0d want 513", n); end
      n_vec++; if (ram[2560] !== 8'hAA || ram[2561] !== 8'h55) begin
         n_bad++; $display("FAIL prog_data got %h %h want aa 55", ram[2560], ram[2561]);
      end
      nff = 0;
      for (int k = 2; k < 512; k++) if (ram[2560 + k] === 8'hFF) nff++;
      n_vec++; if (nff !== 510) begin n_bad++; $display("FAIL prog_fill got %0d want 510", nff); end
   endtask

   task automatic test_status();
      logic [7:0] d; logic oe; bit ready;
      send(1'b1, 1'b0, CMD_PROG, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b1, 8'h07, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b0, 8'h3C, 1'b0);
      send(1'b1, 1'b0, CMD_CONFIRM, 1'b0);
      send(1'b1, 1'b0, CMD_READ0, 1'b0);
      n_vec++; if (bif.f_rb !== 1'b0) begin n_bad++; $display("FAIL busy_ignores_read got rb=%b want 0", bif.f_rb); end
      send(1'b1, 1'b0, CMD_STATUS, 1'b0);
      read_byte(d, oe);
      n_vec++; if (d !== 8'hA0 || oe !== 1'b1) begin n_bad++; $display("FAIL status_busy got %h oe=%b want a0 oe=1", d, oe); end
      ready = 1'b0;
      for (int i = 0; i < 1000 && !ready; i++) begin
         @(negedge clk);
         ready = bif.f_rb;
      end
      n_vec++; if (!ready) begin n_bad++; $display("FAIL status_wait got rb=0 want 1 within 1000 cycles"); end
      read_byte(d, oe);
      n_vec++; if (d !== 8'hE0 || oe !== 1'b1) begin n_bad++; $display("FAIL status_ready got %h oe=%b want e0 oe=1", d, oe); end
      n_vec++; if (ram[7*512] !== 8'h3C) begin n_bad++; $display("FAIL status_prog got %h want 3c", ram[7*512]); end
   endtask

   task automatic test_abort();
      int n; logic [7:0] d; logic oe;
      send(1'b1, 1'b0, CMD_PROG, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b1, 8'h06, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0);
      send(1'b0, 1'b0, 8'h77, 1'b0);
      send(1'b1, 1'b0, CMD_CONFIRM, 1'b1);
      // busy cycle 0 is 3 negedges after this rise; the 0xFF rise below decodes in busy cycle 100
      repeat (50) @(negedge clk);
      bif.f_cle = 1'b1; bif.f_ale = 1'b0; bif.f_io_in = CMD_RESET; bif.f_wen = 1'b0;
      repeat (51) @(negedge clk);
      bif.f_wen = 1'b1;
      repeat (2) @(negedge clk);
      measure_busy(n);
      n_vec++; if (n !== 4) begin n_bad++; $display("FAIL abort_busy got %0d want 4", n); end
      n_vec++; if (ram[3072] !== 8'h77 || ram[3072 + 99] !== 8'hFF) begin
         n_bad++; $display("FAIL abort_written got %h %h want 77 ff", ram[3072], ram[3072 + 99]);
      end
      n_vec++; if (ram[3072 + 100] !== 8'h64 || ram[3072 + 200] !== 8'hC8) begin
         n_bad++; $display("FAIL abort_kept got %h %h want 64 c8", ram[3072 + 100], ram[3072 + 200]);
      end
      send(1'b1, 1'b0, CMD_READ0, 1'b0);
      send(1'b0, 1'b1, 8'h20, 1'b0);
      send(1'b0, 1'b1, 8'h02, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b1);
      measure_busy(n);
      n_vec++; if (n !== 25) begin n_bad++; $display("FAIL post_abort_busy got %0d want 25", n); end
      read_byte(d, oe);
      n_vec++; if (d !== 8'h20) begin n_bad++; $display("FAIL post_abort_read got %h want 20", d); end
   endtask

   initial begin
      bif.f_cle = 1'b0; bif.f_ale = 1'b0; bif.f_wen = 1'b1; bif.f_ren = 1'b1; bif.f_io_in = 8'h00;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_read();
      test_wrap();
      test_program();
      test_status();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/nand_flash_target.md
# nand_flash_target

Synthesizable NAND-flash responder: the device-side end of the CLE/ALE/WEn/REn/IO/R·B interface that the NFC controller drives. It decodes command and address latch cycles, streams page data out on REn and captures page data in on WEn. It reports busy on R/B and backs the 512-page × 512-byte array with an external synchronous RAM. It replaces the behavioural flash models when the copy path is run on an emulation or FPGA build.

## Interface
- `T_R`, 25: read-busy cycles after the address phase of a 0x00/0x01 read.
- `T_PROG`, 200: minimum program-busy cycles after 0x10, including the page write-back.
- `clk` in 1: sole clock; all flash pins are sampled on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `f_cle` in 1: command latch enable.
- `f_ale` in 1: address latch enable.
- `f_wen` in 1: write enable, active low; a latch occurs on the sampled 0→1 edge.
- `f_ren` in 1: read enable, active low.
- `f_io_in` in 8: IO bus, host→target.
- `f_io_out` out 8: IO bus, target→host.
- `f_io_oe` out 1: target drives IO.
- `f_rb` out 1: 1 = ready, 0 = busy.
- `mem_addr` out 18: {row[8:0], col[8:0]}.
- `mem_we` out 1: RAM write strobe.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid 1 cycle after `mem_addr`.

## Operation
- Inputs are registered twice; edges are detected on the second stage. WEn rise with CLE=1 is a command byte, with ALE=1 an address byte, with both low a data byte.
- Commands:
  - 0x00 / 0x01: read, first/second half; `col[8]` = 0/1.
  - 0x80: serial data input; loads the page buffer with 0xFF and sets `col[8]` = 0.
  - 0x10: program confirm.
  - 0x70: read status.
  - 0xFF: reset.
  - Any other byte returns the FSM to IDLE with no effect.
- Address phase is 3 bytes: `col[7:0]`, `row[7:0]`, `row[8]` (bit 0 of the third byte; the other bits are ignored). Any further ALE bytes are ignored.
- States: IDLE → ADDR (after 0x00/0x01/0x80) → RD_BUSY or WR_DATA.
  - RD_BUSY: `f_rb`=0 for `T_R` cycles, then RD_DATA.
  - RD_DATA: `f_io_oe` = ~REn(sampled); `f_io_out` = byte at {row, col}. Each REn rise increments `col` and prefetches the next byte. After col 511 the stream wraps to col 0 of the same page.
  - WR_DATA: each data WEn writes the page buffer at `col` and increments `col` (wraps at 511). 0x10 → PG_BUSY.
  - PG_BUSY: `f_rb`=0; copies all 512 buffer bytes to RAM (one per cycle, `mem_we`=1), then waits until `T_PROG` is reached; then IDLE.
  - STATUS (0x70): a REn-low read returns 0xE0 when ready and 0xA0 when busy. Any command byte leaves STATUS.
- 0xFF is honoured in every state, including busy states. It aborts the operation; the RAM keeps bytes already written. `f_rb` goes low for 4 cycles, then the FSM returns to IDLE.
- All commands except 0x70 and 0xFF are ignored while `f_rb`=0. Data WEn outside WR_DATA is ignored, as is REn outside RD_DATA/STATUS.

## Timing
- Reset values: `f_io_out`=0x00, `f_io_oe`=0, `f_rb`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE, page buffer contents undefined.
- Input-to-decode latency is 3 cycles (2 synchroniser stages plus the edge register). The host must hold WEn high ≥3 cycles and low ≥3 cycles.
- Read data is valid on `f_io_out` ≤2 cycles after the REn fall is sampled. The host must hold REn low ≥3 cycles.
- `f_rb` falls in the cycle after the 3rd address byte (read) or the 0x10 decode. It rises exactly `T_R`, or max(`T_PROG`, 513), cycles later.
- Simultaneous CLE and ALE: the command takes priority and the address is dropped.
- Reset asserted mid-operation: all state returns to reset values on the next clock edge.

## Structure
- Package `nand_pkg`:
  - command constants (`CMD_READ0`, `CMD_READ1`, `CMD_PROG`, `CMD_CONFIRM`, `CMD_STATUS`, `CMD_RESET`);
  - state enum;
  - `PAGE_BYTES`=512, `PAGES`=512;
  - status byte values.
- Sub-module `nand_page_buf`: 512×8 single-port synchronous buffer with 1-cycle read. It is used in WR_DATA for writes and in PG_BUSY for the copy-out.

## Test plan
- Reset with IO idle → `f_rb`=1, `f_io_oe`=0, `f_io_out`=0x00; WEn pulses without CLE or ALE → no RAM write.
- RAM preloaded with `mem[k]`=k[7:0]; issue 0x00 with address 0x10,0x03,0x00 → `f_rb` low for exactly 25 cycles; 4 REn reads return 0x10,0x11,0x12,0x13 (address 0x0610).
- 0x01 with address 0xFE,0x01,0x01 (row 257), then 4 reads → bytes at col 510, 511, 0, 1, showing wrap-around within the page.
- 0x80, address 0,5,0, 2 data bytes 0xAA,0x55, then 0x10 → `f_rb` low for 513 cycles (`T_PROG`=200). RAM page 5 = AA,55 followed by 510×FF.
- During PG_BUSY, send 0x70 and read → 0xA0; after `f_rb` rises, read → 0xE0; a 0x00 sent while busy is ignored.
- 0xFF at cycle 100 of PG_BUSY → `f_rb` rises 4 cycles later; page bytes 0–99 are written and the rest keep their old contents; a following 0x00 read works normally.
